fetch_unit: RTL and testbench

Instruction fetch stage for the WISC-15 16-bit processor, producing the instruction stream that the control unit decodes. It holds the PC and issues single-outstanding reads to instruction memory, then presents each fetched word to the decode stage with a valid/stall handshake. It applies PC redirects for B, CALL and RET, and stops fetching permanently once a HLT (opcode 4'hF) has been accepted by decode.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: WISC-15 instruction fetch stage with a single outstanding read, a decode handshake, redirects and halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd_en_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_rdy_i,
  input  logic [15:0] imem_data_i,
  output logic [15:0] inst_o,
  output logic        inst_vld_o,
  output logic [15:0] inst_pc_plus1_o,
  input  logic        dec_stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        halted_o
);
  typedef enum logic [1:0] {FETCH, VALID, HALTED} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, inst_q, inst_d, pcp1_q, pcp1_d, tgt_q, tgt_d;
  logic        pend_q, pend_d, rd_en_q, vld_q, halted_q;
  logic        rsp;
  // A response only counts while a request is actually on the bus.
  assign rsp = imem_rdy_i && rd_en_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcp1_d  = pcp1_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    case (state_q)
      FETCH: begin
        if (rsp) begin
          if (pend_q || redirect_i) begin
            pc_d   = redirect_i ? redirect_pc_i : tgt_q;
            pend_d = 1'b0;
          end else begin
            inst_d  = imem_data_i;
            pcp1_d  = pc_q + 16'd1;
            pc_d    = pc_q + 16'd1;
            state_d = VALID;
          end
        end else if (redirect_i) begin
          // Keep the bus stable while a read is outstanding; otherwise retarget at once.
          tgt_d  = rd_en_q ? redirect_pc_i : tgt_q;
          pend_d = rd_en_q;
          pc_d   = rd_en_q ? pc_q : redirect_pc_i;
        end
      end
      VALID: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = FETCH;
        end else if (!dec_stall_i) begin
          state_d = (inst_q[15:12] == HLT_OP) ? HALTED : FETCH;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      inst_q   <= 16'h0000;
      pcp1_q   <= 16'h0000;
      tgt_q    <= 16'h0000;
      pend_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pcp1_q   <= pcp1_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      rd_en_q  <= state_d == FETCH;
      vld_q    <= state_d == VALID;
      halted_q <= state_d == HALTED;
    end
  end
  assign imem_rd_en_o    = rd_en_q;
  assign imem_addr_o     = pc_q;
  assign inst_o          = inst_q;
  assign inst_vld_o      = vld_q;
  assign inst_pc_plus1_o = pcp1_q;
  assign halted_o        = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit, plus a RESET_PC=FFFF instance for PC wrap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy = 1'b0, stall = 1'b0, redir = 1'b0;
  logic [15:0] data = 16'h0000, redir_pc = 16'h0000;
  logic        rd_en, vld, halted, w_rd_en, w_vld, w_halted;
  logic [15:0] addr, inst, pcp1, w_addr, w_inst, w_pcp1;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_rd_en_o(rd_en), .imem_addr_o(addr),
    .imem_rdy_i(rdy), .imem_data_i(data), .inst_o(inst), .inst_vld_o(vld),
    .inst_pc_plus1_o(pcp1), .dec_stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(redir_pc), .halted_o(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_rd_en_o(w_rd_en), .imem_addr_o(w_addr),
    .imem_rdy_i(rdy), .imem_data_i(data), .inst_o(w_inst), .inst_vld_o(w_vld),
    .inst_pc_plus1_o(w_pcp1), .dec_stall_i(stall), .redirect_i(1'b0),
    .redirect_pc_i(16'h0000), .halted_o(w_halted)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch at address a returning d after `waits` idle cycles, held in VALID for `hold` stall cycles.
  task automatic fetch(input logic [15:0] a, input logic [15:0] d, input int waits, input int hold);
    for (int i = 0; i < waits; i++) begin
      chk("wait_rd_en", {15'd0, rd_en}, 16'd1);
      chk("wait_addr", addr, a);
      tick();
    end
    chk("rd_en", {15'd0, rd_en}, 16'd1);
    chk("addr", addr, a);
    data = d;
    rdy  = 1'b1;
    tick();
    rdy   = 1'b0;
    stall = hold > 0;
    chk("vld", {15'd0, vld}, 16'd1);
    chk("inst", inst, d);
    chk("pcp1", pcp1, a + 16'd1);
    chk("rd_en_valid", {15'd0, rd_en}, 16'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("stall_vld", {15'd0, vld}, 16'd1);
      chk("stall_inst", inst, d);
    end
    stall = 1'b0;
    tick();
    chk("vld_after_accept", {15'd0, vld}, 16'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", {15'd0, rd_en}, 16'd0);
    chk("rst_vld", {15'd0, vld}, 16'd0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_pcp1", pcp1, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_addr", addr, 16'h0000);
    chk("w_rst_addr", w_addr, 16'hFFFF);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fetch(16'h0000, 16'h0000, 0, 0);
    chk("w_pcp1_wrap", w_pcp1, 16'h0000);
    chk("w_addr_wrap", w_addr, 16'h0000);
    fetch(16'h0001, 16'h0001, 0, 0);
    fetch(16'h0002, 16'h0002, 0, 0);
    fetch(16'h0003, 16'h0003, 3, 4);
    chk("pc_once", addr, 16'h0004);
    fetch(16'h0004, 16'h0004, 0, 0);
    // redirect while VALID and not stalled: the instruction is dropped
    chk("addr5", addr, 16'h0005);
    data = 16'h1234;
    rdy  = 1'b1;
    tick();
    rdy = 1'b0;
    chk("vld5", {15'd0, vld}, 16'd1);
    redir    = 1'b1;
    redir_pc = 16'h0040;
    tick();
    redir = 1'b0;
    chk("redir_vld", {15'd0, vld}, 16'd0);
    chk("redir_rd_en", {15'd0, rd_en}, 16'd1);
    chk("redir_addr", addr, 16'h0040);
    // redirect two cycles before the response
    redir    = 1'b1;
    redir_pc = 16'h0100;
    tick();
    redir = 1'b0;
    chk("pend_addr_hold", addr, 16'h0040);
    tick();
    chk("pend_addr_hold2", addr, 16'h0040);
    data = 16'h5555;
    rdy  = 1'b1;
    tick();
    rdy = 1'b0;
    chk("discard_vld", {15'd0, vld}, 16'd0);
    chk("discard_addr", addr, 16'h0100);
    chk("discard_rd_en", {15'd0, rd_en}, 16'd1);
    // halt
    fetch(16'h0100, 16'hF000, 1, 0);
    chk("halted", {15'd0, halted}, 16'd1);
    chk("halt_rd_en", {15'd0, rd_en}, 16'd0);
    redir    = 1'b1;
    redir_pc = 16'h0200;
    rdy      = 1'b1;
    tick();
    redir = 1'b0;
    rdy   = 1'b0;
    tick();
    chk("halt_stays", {15'd0, halted}, 16'd1);
    chk("halt_rd_en2", {15'd0, rd_en}, 16'd0);
    chk("halt_vld", {15'd0, vld}, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("halt_rst", {15'd0, halted}, 16'd0);
    chk("halt_rst_addr", addr, 16'h0000);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_rd_en", {15'd0, rd_en}, 16'd1);
    chk("post_rst_addr", addr, 16'h0000);
    // asynchronous reset mid-FETCH
    #3 rst_n = 1'b0;
    #1;
    chk("async_fetch_rd_en", {15'd0, rd_en}, 16'd0);
    chk("async_fetch_vld", {15'd0, vld}, 16'd0);
    rst_n = 1'b1;
    tick();
    data = 16'h0ABC;
    rdy  = 1'b1;
    tick();
    rdy = 1'b0;
    chk("pre_async_vld", {15'd0, vld}, 16'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid_vld", {15'd0, vld}, 16'd0);
    chk("async_valid_inst", inst, 16'h0000);
    chk("async_valid_pcp1", pcp1, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("final_addr", addr, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
